timer_ctrl_master: RTL

- Avalon-MM initiator that programs and services the on-chip 16-bit-register interval timer (6-word register map) on behalf of fabric logic.
- On `start` it stops the timer, loads the 32-bit period, and starts it (one-shot or continuous). It then detects each timeout, clears the status, and emits a one-cycle tick and a running tick count.
- Sits between control logic and the timer's s1 slave port. No CPU involvement.

---
 rtl/timer_ctrl_master.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator that programs an interval timer and services its timeouts.
// Build option: define TIMER_CTRL_IRQ_EN to service timeouts from irq instead of status polling.
module timer_ctrl_master #(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      period_in,
    input  logic             continuous_in,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    input  logic             irq
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_STOP  = 4'd1;
    localparam logic [3:0] S_WR_PL    = 4'd2;
    localparam logic [3:0] S_WR_PH    = 4'd3;
    localparam logic [3:0] S_WR_CTRL  = 4'd4;
    localparam logic [3:0] S_WR_CLR0  = 4'd5;
    localparam logic [3:0] S_RUN      = 4'd6;
    localparam logic [3:0] S_POLL_A   = 4'd7;
    localparam logic [3:0] S_POLL_S   = 4'd8;
    localparam logic [3:0] S_WR_CLR   = 4'd9;
    localparam logic [3:0] S_STOPPING = 4'd10;

    localparam logic [2:0]  A_STATUS   = 3'd0;
    localparam logic [2:0]  A_CONTROL  = 3'd1;
    localparam logic [2:0]  A_PERIOD_L = 3'd2;
    localparam logic [2:0]  A_PERIOD_H = 3'd3;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

`ifdef TIMER_CTRL_IRQ_EN
    localparam logic CTRL_ITO = 1'b1;
`else
    localparam logic CTRL_ITO = 1'b0;
    localparam logic [7:0] GAP_RELOAD = 8'(POLL_GAP);
`endif

    logic [3:0]       state_q,     state_d;
    logic [31:0]      period_q,    period_d;
    logic             cont_q,      cont_d;
    logic             stop_pend_q, stop_pend_d;
    logic             tick_q,      tick_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic             cs_q,    cs_d;
    logic             wr_n_q,  wr_n_d;
    logic [2:0]       addr_q,  addr_d;
    logic [15:0]      wdata_q, wdata_d;

    logic             stop_req;

`ifdef TIMER_CTRL_IRQ_EN
    logic             irq_mask_q, irq_mask_d;
    logic             unused_rdata;
    assign unused_rdata = ^avm_readdata[15:1];
`else
    logic [7:0]       gap_q, gap_d;
    logic             unused_inputs;
    assign unused_inputs = ^{irq, avm_readdata[15:1]};
`endif

    // A stop seen anywhere in the sequence is remembered until the next write slot acts on it.
    assign stop_req = stop | stop_pend_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        period_d    = period_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        tick_d      = 1'b0;
        count_d     = count_q;

        if (state_q != S_IDLE && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    period_d = period_in;
                    cont_d   = continuous_in;
                    count_d  = '0;
                    state_d  = S_WR_STOP;
                end
            end
            S_WR_STOP: state_d = stop_req ? S_STOPPING : S_WR_PL;
            S_WR_PL:   state_d = stop_req ? S_STOPPING : S_WR_PH;
            S_WR_PH:   state_d = stop_req ? S_STOPPING : S_WR_CTRL;
            S_WR_CTRL: state_d = stop_req ? S_STOPPING : S_WR_CLR0;
            S_WR_CLR0: state_d = stop_req ? S_STOPPING : S_RUN;
            S_RUN: begin
`ifdef TIMER_CTRL_IRQ_EN
                // A timeout seen together with stop still gets its status cleared, but no tick.
                if (irq && !irq_mask_q) begin
                    state_d = S_WR_CLR;
                end else if (stop_req) begin
                    state_d = S_STOPPING;
                end
`else
                if (stop_req) begin
                    state_d = S_STOPPING;
                end else if (gap_q <= 8'd1) begin
                    state_d = S_POLL_A;
                end
`endif
            end
            S_POLL_A: state_d = S_POLL_S;
            S_POLL_S: begin
                if (avm_readdata[0]) begin
                    state_d = S_WR_CLR;
                end else if (stop_req) begin
                    state_d = S_STOPPING;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_WR_CLR: begin
                if (stop_pend_q) begin
                    state_d = S_STOPPING;
                end else begin
                    tick_d  = 1'b1;
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (stop) begin
                        state_d = S_STOPPING;
                    end else begin
                        state_d = cont_q ? S_RUN : S_IDLE;
                    end
                end
            end
            S_STOPPING: begin
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so the slave sees glitch-free signals.
    always_comb begin
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = A_STATUS;
        wdata_d = 16'h0000;
        case (state_d)
            S_WR_STOP, S_STOPPING: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = A_CONTROL;
                wdata_d = CTRL_STOP;
            end
            S_WR_PL: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = A_PERIOD_L;
                wdata_d = period_d[15:0];
            end
            S_WR_PH: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = A_PERIOD_H;
                wdata_d = period_d[31:16];
            end
            S_WR_CTRL: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = A_CONTROL;
                wdata_d = {12'h000, 1'b0, 1'b1, cont_d, CTRL_ITO};
            end
            S_WR_CLR0, S_WR_CLR: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = A_STATUS;
                wdata_d = 16'h0000;
            end
            S_POLL_A: begin
                cs_d    = 1'b1;
                addr_d  = A_STATUS;
            end
            default: ;
        endcase
    end

`ifdef TIMER_CTRL_IRQ_EN
    // The slave's irq may still be high the cycle after our clear write lands.
    assign irq_mask_d = (state_q == S_WR_CLR);
`else
    always_comb begin
        gap_d = gap_q;
        if (state_d == S_RUN && state_q != S_RUN) begin
            gap_d = GAP_RELOAD;
        end else if (state_q == S_RUN && gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            tick_q      <= 1'b0;
            count_q     <= '0;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            tick_q      <= tick_d;
            count_q     <= count_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef TIMER_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign busy           = (state_q != S_IDLE);
    assign tick           = tick_q;
    assign tick_count     = count_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;

endmodule
